// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions for the core arbiter and its HMAC users.
//   BLOCK_W / DIGEST_W : SHA-1 block and digest widths
//   state_t            : arbiter FSM states
//   HMAC_IPAD/OPAD     : HMAC inner/outer pad blocks
package sha1_pkg;
    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 160;

    typedef enum logic [2:0] {
        IDLE,
        OWN,
        WAIT_LOW,
        WAIT_HIGH,
        PARK
    } state_t;

    localparam logic [BLOCK_W-1:0] HMAC_IPAD = {64{8'h36}};
    localparam logic [BLOCK_W-1:0] HMAC_OPAD = {64{8'h5c}};
endpackage

// File: rtl/sha1_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req     : request vector
//   ptr     : index of the last granted requester
//   win     : one-hot winner (first requester above ptr, wrapping)
//   win_idx : binary index of the winner
//   found   : at least one request present
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             found
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // offset NREQ lands back on ptr itself, so it has lowest priority
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/sha1_arbiter.sv
// sha1_arbiter: shares one SHA-1 core between NREQ requesters.
//   req/gnt             : level request per requester, registered one-hot grant
//   cli_init/cli_next   : command pulses from requesters (only the granted one counts)
//   cli_block           : packed blocks, requester i at [i*BLOCK_W +: BLOCK_W]
//   cli_ready           : ready to the granted requester while the core is idle
//   cli_digest          : core digest broadcast to everyone
//   sha1_init/next/block: registered command to the core
//   sha1_ready/digest   : core status and result
//   proto_err           : sticky protocol error flag
module sha1_arbiter #(
    parameter int NREQ        = 2,
    parameter int BLOCK_W     = sha1_pkg::BLOCK_W,
    parameter int DIGEST_W    = sha1_pkg::DIGEST_W,
    parameter int LOW_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    input  logic [NREQ-1:0]         cli_init,
    input  logic [NREQ-1:0]         cli_next,
    input  logic [NREQ*BLOCK_W-1:0] cli_block,
    output logic [NREQ-1:0]         cli_ready,
    output logic [DIGEST_W-1:0]     cli_digest,
    output logic                    sha1_init,
    output logic                    sha1_next,
    output logic [BLOCK_W-1:0]      sha1_block,
    input  logic                    sha1_ready,
    input  logic [DIGEST_W-1:0]     sha1_digest,
    output logic                    proto_err
);
    import sha1_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (LOW_TIMEOUT > 1) ? $clog2(LOW_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOW_TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   low_cnt;
    logic [NREQ-1:0]    win;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [BLOCK_W-1:0] g_block;
    logic               g_init, g_next, g_req;
    logic               cmd_any, stray_cmd, dual_cmd, timeout, err_now;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .found   (win_found)
    );

    // gnt is one-hot, so masking selects the owner's signals
    always_comb begin
        g_block = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) g_block |= cli_block[i*BLOCK_W +: BLOCK_W];
    end

    assign g_init  = |(cli_init & gnt);
    assign g_next  = |(cli_next & gnt);
    assign g_req   = |(req & gnt);
    assign cmd_any = |(cli_init | cli_next);

    // commands from non-owners or outside OWN are dropped and flagged
    assign stray_cmd = (|((cli_init | cli_next) & ~gnt)) || (state != OWN && cmd_any);
    assign dual_cmd  = (state == OWN) && g_init && g_next;
    assign timeout   = (state == WAIT_LOW) && sha1_ready && (low_cnt == CNT_LIM);
    assign err_now   = stray_cmd || dual_cmd || timeout;

    assign cli_ready  = gnt & {NREQ{(state == OWN) && sha1_ready}};
    assign cli_digest = sha1_digest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NREQ - 1);
            gnt        <= '0;
            low_cnt    <= '0;
            sha1_init  <= 1'b0;
            sha1_next  <= 1'b0;
            sha1_block <= '0;
            proto_err  <= 1'b0;
        end else begin
            sha1_init <= 1'b0;
            sha1_next <= 1'b0;
            if (err_now) proto_err <= 1'b1;
            unique case (state)
                IDLE: if (win_found) begin
                    gnt   <= win;
                    ptr   <= win_idx;
                    state <= OWN;
                end
                // a command in the same cycle as a req drop still goes out;
                // the release then happens once it completes
                OWN: if (g_init || g_next) begin
                    sha1_block <= g_block;
                    sha1_init  <= g_init;
                    sha1_next  <= g_next && !g_init;
                    low_cnt    <= '0;
                    state      <= WAIT_LOW;
                end else if (!g_req) begin
                    gnt   <= '0;
                    state <= PARK;
                end
                // core must acknowledge by dropping ready; if it never does,
                // give the requester the core back and flag it
                WAIT_LOW: if (!sha1_ready) begin
                    state <= WAIT_HIGH;
                end else if (low_cnt == CNT_LIM) begin
                    state <= OWN;
                end else begin
                    low_cnt <= low_cnt + 1'b1;
                end
                WAIT_HIGH: if (sha1_ready) begin
                    if (g_req) begin
                        state <= OWN;
                    end else begin
                        gnt   <= '0;
                        state <= PARK;
                    end
                end
                PARK:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_arbiter.sv
// Scoreboard bench for sha1_arbiter: stimulus pushes expected core commands
// and grant order into queues; monitors pop and compare on DUT activity.
module tb_sha1_arbiter;
    localparam int NREQ = 2;
    localparam int BW   = 512;
    localparam int DW   = 160;
    localparam int BUSY = 3;
    localparam logic [DW-1:0] DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

    typedef struct {
        logic          init;
        logic          nxt;
        logic [BW-1:0] blk;
    } cmd_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     cli_init = '0;
    logic [NREQ-1:0]     cli_next = '0;
    logic [NREQ*BW-1:0]  cli_block = '0;
    logic [NREQ-1:0]     cli_ready;
    logic [DW-1:0]       cli_digest;
    logic                sha1_init, sha1_next;
    logic [BW-1:0]       sha1_block;
    logic                sha1_ready;
    logic [DW-1:0]       sha1_digest;
    logic                proto_err;

    int checks = 0;
    int errors = 0;
    int hold_hi = 0;
    cmd_t cq[$];
    logic [NREQ-1:0] gq[$];

    sha1_arbiter #(.NREQ(NREQ), .BLOCK_W(BW), .DIGEST_W(DW), .LOW_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .cli_init(cli_init), .cli_next(cli_next), .cli_block(cli_block),
        .cli_ready(cli_ready), .cli_digest(cli_digest),
        .sha1_init(sha1_init), .sha1_next(sha1_next), .sha1_block(sha1_block),
        .sha1_ready(sha1_ready), .sha1_digest(sha1_digest), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // core model: after a command, ready stays high hold_hi cycles, then low BUSY cycles
    initial begin
        int mph, mcnt;
        mph = 0; mcnt = 0;
        sha1_ready = 1'b1; sha1_digest = DIG;
        forever begin
            @(posedge clk); #2;
            if (!rst) begin
                sha1_ready = 1'b1; sha1_digest = DIG; mph = 0;
            end else if (mph == 0) begin
                if (sha1_init || sha1_next) begin
                    if (hold_hi == 0) begin
                        sha1_ready = 1'b0; sha1_digest = '0; mcnt = BUSY; mph = 2;
                    end else begin
                        mcnt = hold_hi; mph = 1;
                    end
                end
            end else if (mph == 1) begin
                mcnt--;
                if (mcnt == 0) begin
                    sha1_ready = 1'b0; sha1_digest = '0; mcnt = BUSY; mph = 2;
                end
            end else begin
                mcnt--;
                if (mcnt == 0) begin
                    sha1_ready = 1'b1; sha1_digest = DIG; mph = 0;
                end
            end
        end
    end

    // core command monitor
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst && (sha1_init || sha1_next)) begin
                if (cq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got init=%b next=%b expected none", sha1_init, sha1_next);
                end else begin
                    e = cq.pop_front();
                    chk("cmd_init", sha1_init, e.init);
                    chk("cmd_next", sha1_next, e.nxt);
                    chk("cmd_block", sha1_block, e.blk);
                end
            end
        end
    end

    // grant order monitor
    initial begin
        logic [NREQ-1:0] prev, eg;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst && gnt != prev && gnt != '0) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL grant_unexpected: got %b expected none", gnt);
                end else begin
                    eg = gq.pop_front();
                    chk("grant_order", gnt, eg);
                end
            end
            prev = rst ? gnt : '0;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; cli_init = '0; cli_next = '0; hold_hi = 0;
        rst = 1'b0;
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_init", sha1_init, 0);
        chk("rst_next", sha1_next, 0);
        chk("rst_block", sha1_block, 0);
        chk("rst_err", proto_err, 0);
        rst = 1'b1;
    endtask

    // drive a valid command at the current negedge; returns one cycle later
    task automatic issue(input int idx, input logic ini, input logic nxt, input logic [BW-1:0] blk);
        cmd_t e;
        cli_block[idx*BW +: BW] = blk;
        cli_init[idx] = ini;
        cli_next[idx] = nxt;
        e.init = ini; e.nxt = nxt & ~ini; e.blk = blk;
        cq.push_back(e);
        step();
        cli_init = '0; cli_next = '0;
        chk("ready_low_after_cmd", cli_ready[idx], 0);
    endtask

    task automatic wait_rdy(input int idx, output int n);
        n = 0;
        do begin step(); n++; end while (!cli_ready[idx] && n < 50);
        if (n >= 50) begin checks++; errors++; $display("FAIL ready_timeout: got 0 expected 1"); end
    endtask

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        while (!gnt[idx] && n < 50) begin step(); n++; end
        if (n >= 50) begin checks++; errors++; $display("FAIL gnt_timeout: got 0 expected 1"); end
    endtask

    initial begin
        int n;
        logic [BW-1:0] ipad, opad, b3, b4;
        ipad = {64{8'h36}}; opad = {64{8'h5c}};
        b3 = {16{32'hdeadbeef}}; b4 = {16{32'h01234567}};

        // single requester
        do_reset();
        req = 2'b01; gq.push_back(2'b01);
        step();
        chk("single_gnt", gnt, 2'b01);
        chk("single_ready", cli_ready, 2'b01);
        issue(0, 1'b1, 1'b0, ipad);
        wait_rdy(0, n);
        chk("single_ready_latency", n, 4);
        chk("single_digest", cli_digest, DIG);
        chk("single_err", proto_err, 0);
        req = '0;
        step();
        chk("single_release", gnt, 0);

        // contention + fairness
        do_reset();
        req = 2'b11;
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        step();
        chk("contend_first", gnt, 2'b01);
        issue(0, 1'b1, 1'b0, ipad);
        wait_rdy(0, n);
        req[0] = 1'b0;
        step(); chk("handoff_park", gnt, 0);
        step(); chk("handoff_idle", gnt, 0);
        step(); chk("handoff_t3", gnt, 2'b10);
        req[0] = 1'b1;
        issue(1, 1'b0, 1'b1, opad);
        wait_rdy(1, n);
        req[1] = 1'b0; step(); req[1] = 1'b1;
        wait_gnt(0);
        issue(0, 1'b0, 1'b1, b3);
        wait_rdy(0, n);
        req[0] = 1'b0; step(); req[0] = 1'b1;
        wait_gnt(1);
        issue(1, 1'b1, 1'b0, b4);
        wait_rdy(1, n);
        req = '0;
        step(); step();

        // drop request while core busy
        do_reset();
        req = 2'b01; gq.push_back(2'b01);
        step();
        issue(0, 1'b0, 1'b1, b3);
        step();
        req[0] = 1'b0;
        step(); chk("drop_hold1", gnt, 2'b01);
        step(); chk("drop_hold2", gnt, 2'b01);
        step(); chk("drop_park", gnt, 0);
        chk("drop_ready", cli_ready, 0);
        step(); chk("drop_idle", gnt, 0);

        // timeout: core never drops ready within 4 cycles
        do_reset();
        hold_hi = 5;
        req = 2'b01; gq.push_back(2'b01);
        step();
        issue(0, 1'b1, 1'b0, ipad);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo_err_early", proto_err, 0);
            chk("tmo_ready_early", cli_ready, 0);
        end
        step();
        chk("tmo_err", proto_err, 1);
        chk("tmo_own", cli_ready, 2'b01);

        // protocol errors, then reset mid WAIT_HIGH
        do_reset();
        req = 2'b01; gq.push_back(2'b01);
        step();
        cli_next[1] = 1'b1;
        step();
        cli_next = '0;
        chk("stray_err", proto_err, 1);
        chk("stray_no_next", sha1_next, 0);
        issue(0, 1'b1, 1'b1, opad);
        step();
        rst = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_init", sha1_init, 0);
        chk("arst_next", sha1_next, 0);
        chk("arst_block", sha1_block, 0);
        chk("arst_err", proto_err, 0);
        chk("arst_ready", cli_ready, 0);
        do_reset();
        step(); step();

        chk("cmd_queue_empty", cq.size(), 0);
        chk("gnt_queue_empty", gq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
